regfile_mp: RTL

- Parametrised successor of the core's 2-read/1-write integer register file.
- Configurable data width, register count and number of read ports.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for hazard detection.
- Adds a post-reset clear sequencer that zeroes the array one entry per cycle, so the storage maps to RAM without per-bit reset.
- Sits between decode (read/scoreboard) and writeback (write/clear).

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write-to-read bypass, a busy
// scoreboard for hazard detection and a post-reset clear sweep.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reg_write_enable,
    input  logic [AW-1:0]            write_addr,
    input  logic [XLEN-1:0]          write_data,
    input  logic [NUM_RD*AW-1:0]     read_addr,
    output logic [NUM_RD*XLEN-1:0]   read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     set_busy,
    input  logic [AW-1:0]            set_addr,
    output logic                     ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic              ready_q;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    logic              wr_eff;
    logic              set_eff;
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [XLEN-1:0]   mem_wd;

    // An address is architecturally writable/readable: in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_eff  = ready_q && reg_write_enable && addr_ok(write_addr);
    assign set_eff = ready_q && set_busy && addr_ok(set_addr);
    assign ready   = ready_q;

    // Clear sequencer: one entry per edge, then hand over to normal operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (ptr_q == AW'(NREGS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Single physical write port shared by the sweep and writeback; no reset so it maps to RAM.
    assign mem_we = (state_q == ST_INIT) || wr_eff;
    assign mem_wa = (state_q == ST_INIT) ? ptr_q : write_addr;
    assign mem_wd = (state_q == ST_INIT) ? '0 : write_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Scoreboard: a same-cycle set overrides the clear from the retiring producer.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[write_addr] = 1'b0;
        end
        if (set_eff) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < int'(NUM_RD); gi++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata_c;
        logic            rbusy_c;

        assign ra = read_addr[gi*AW +: AW];

        always_comb begin
            rdata_c = '0;
            rbusy_c = 1'b0;
            if (ready_q && addr_ok(ra)) begin
                if ((BYPASS != 0) && wr_eff && (write_addr == ra)) begin
                    rdata_c = write_data;
                end else begin
                    rdata_c = mem_q[ra];
                    rbusy_c = busy_q[ra];
                end
            end
        end

        assign read_data[gi*XLEN +: XLEN] = rdata_c;
        assign read_busy[gi]              = rbusy_c;
    end

endmodule
